// File: rtl/tmds_rx_decoder_if.sv
// Bus between a TMDS deserializer lane and its decoder: the 10-bit symbol in,
// the decoded pixel/control data and the alignment handshake out.
interface tmds_rx_decoder_if;
  logic [9:0] i_tmds_word;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_bitslip;
  logic       o_aligned;

  modport master (
    output i_tmds_word,
    input  o_data, o_ctrl, o_de, o_bitslip, o_aligned
  );

  modport slave (
    input  i_tmds_word,
    output o_data, o_ctrl, o_de, o_bitslip, o_aligned
  );
endinterface

// File: rtl/tmds_rx_decoder.sv
// TMDS symbol decoder with control-token based word alignment and bitslip request.
// Two-stage pipeline: symbol register, then registered decode plus alignment FSM.
module tmds_rx_decoder #(
  parameter int CTRL_RUN       = 16,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 8
) (
  input  logic               i_pixclk,
  input  logic               i_reset,
  tmds_rx_decoder_if.slave   bus
);

  typedef enum logic [1:0] {ST_SEARCH, ST_SLIP, ST_WAIT, ST_LOCKED} state_e;

  localparam int RW  = $clog2(CTRL_RUN + 1);
  localparam int TW  = $clog2(SEARCH_TIMEOUT);
  localparam int TW1 = TW + 1;
  localparam logic [RW-1:0] RUN_MAX   = RW'(CTRL_RUN);
  localparam logic [TW:0]   TIMEOUT_C = TW1'(SEARCH_TIMEOUT);
  localparam logic [TW:0]   WAIT_C    = TW1'(SLIP_WAIT);

  logic [9:0]    word_q;
  logic          valid_q;
  state_e        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          de_q, de_d;

  logic          is_tok;
  logic [1:0]    tok_val;
  logic [7:0]    d_word;
  logic [7:0]    dec_data;
  logic [TW:0]   timer_inc;

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (word_q)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase
  end

  always_comb begin
    dec_data    = '0;
    d_word      = word_q[9] ? ~word_q[7:0] : word_q[7:0];
    dec_data[0] = d_word[0];
    for (int i = 1; i < 8; i++) begin
      dec_data[i] = word_q[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
    end
  end

  // Outputs only move once a real symbol has reached stage 1 after reset.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    de_d   = de_q;
    if (valid_q) begin
      if (is_tok) begin
        data_d = 8'h00;
        ctrl_d = tok_val;
        de_d   = 1'b0;
      end else begin
        data_d = dec_data;
        de_d   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    timer_d   = timer_q;
    timer_inc = {1'b0, timer_q} + TW1'(1);
    if (valid_q) begin
      if (is_tok) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
      end else begin
        run_d = '0;
      end
      case (state_q)
        ST_SEARCH: begin
          // Lock is checked first so a run completing on the timeout word wins.
          if (run_d == RUN_MAX) begin
            state_d = ST_LOCKED;
            timer_d = '0;
          end else if (timer_inc == TIMEOUT_C) begin
            state_d = ST_SLIP;
            timer_d = '0;
          end else begin
            timer_d = timer_inc[TW-1:0];
          end
        end
        ST_SLIP: begin
          state_d = ST_WAIT;
          run_d   = '0;
          timer_d = '0;
        end
        ST_WAIT: begin
          run_d = '0;
          if (timer_inc == WAIT_C) begin
            state_d = ST_SEARCH;
            timer_d = '0;
          end else begin
            timer_d = timer_inc[TW-1:0];
          end
        end
        ST_LOCKED: begin
          if (is_tok) begin
            timer_d = '0;
          end else if (timer_inc == TIMEOUT_C) begin
            state_d = ST_SEARCH;
            timer_d = '0;
          end else begin
            timer_d = timer_inc[TW-1:0];
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      state_q <= ST_SEARCH;
      run_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      de_q    <= 1'b0;
    end else begin
      word_q  <= bus.i_tmds_word;
      valid_q <= 1'b1;
      state_q <= state_d;
      run_q   <= run_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      de_q    <= de_d;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_ctrl    = ctrl_q;
  assign bus.o_de      = de_q;
  assign bus.o_bitslip = (state_q == ST_SLIP);
  assign bus.o_aligned = (state_q == ST_LOCKED);

endmodule
